draw_letters: RTL

DRAW_LETTERS -- requirements
Module: draw_letters

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_if.sv | 13 +
 rtl/vga_delay.sv | 26 ++
 rtl/draw_letters.sv | 97 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the label overlay and its font address generator.
package vga_pkg;

  localparam logic [10:0] TOP_V_START   = 11'd104;
  localparam logic [10:0] TOP_V_END     = 11'd120;
  localparam logic [10:0] BOT_V_START   = 11'd648;
  localparam logic [10:0] BOT_V_END     = 11'd664;
  localparam logic [10:0] COL_V_START   = 11'd128;
  localparam logic [10:0] COL_V_END     = 11'd640;
  localparam logic [10:0] LEFT_H_START  = 11'd236;
  localparam logic [10:0] LEFT_H_END    = 11'd244;
  localparam logic [10:0] RIGHT_H_START = 11'd780;
  localparam logic [10:0] RIGHT_H_END   = 11'd788;
  localparam logic [10:0] BAND_H_START  = 11'd256;
  localparam logic [10:0] BAND_H_END    = 11'd768;
  localparam logic [10:0] GLYPH_OFFSET  = 11'd28;
  localparam logic [10:0] GLYPH_WIDTH   = 11'd8;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_fields_t;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_BAND,
    REGION_LEFT,
    REGION_RIGHT
  } region_t;

  function automatic logic in_range(input logic [10:0] value, input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing plus background colour bundle passed between drawing stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// Fixed-depth register pipeline for the packed VGA fields, cleared by synchronous reset.
module vga_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  vga_fields_t source,
  output vga_fields_t delayed
);

  vga_fields_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= source;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign delayed = stages[DEPTH-1];

endmodule

// File: rtl/draw_letters.sv
// Overlays font glyph pixels on the VGA stream inside the label bands and columns.
module draw_letters
  import vga_pkg::*;
#(
  parameter int          ROM_LATENCY  = 1,
  parameter logic [11:0] LETTER_COLOR = 12'hFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_pixels,
  vga_if.in          vga_in,
  vga_if.out         vga_out
);

  vga_fields_t source;
  vga_fields_t aligned;
  region_t     region;
  logic [10:0] column;
  logic [10:0] hmod;
  logic        column_valid;
  logic        pixel_on;

  assign source = '{hcount: vga_in.hcount, vcount: vga_in.vcount, hsync: vga_in.hsync,
                    vsync: vga_in.vsync, hblnk: vga_in.hblnk, vblnk: vga_in.vblnk,
                    rgb: vga_in.rgb};

  // Delay the fields so they line up with the ROM row fetched for them.
  vga_delay #(.DEPTH(ROM_LATENCY)) u_delay (
    .clk     (clk),
    .rst     (rst),
    .source  (source),
    .delayed (aligned)
  );

  assign hmod = {5'd0, aligned.hcount[5:0]};

  always_comb begin
    region       = REGION_NONE;
    column       = '0;
    column_valid = 1'b0;
    pixel_on     = 1'b0;

    if (in_range(aligned.hcount, BAND_H_START, BAND_H_END) &&
        (in_range(aligned.vcount, TOP_V_START, TOP_V_END) ||
         in_range(aligned.vcount, BOT_V_START, BOT_V_END))) begin
      region = REGION_BAND;
    end else if (in_range(aligned.vcount, COL_V_START, COL_V_END)) begin
      if (in_range(aligned.hcount, LEFT_H_START, LEFT_H_END))
        region = REGION_LEFT;
      else if (in_range(aligned.hcount, RIGHT_H_START, RIGHT_H_END))
        region = REGION_RIGHT;
    end

    // Each subtraction only happens once its operand is known to be in range.
    case (region)
      REGION_BAND: begin
        if (in_range(hmod, GLYPH_OFFSET, GLYPH_OFFSET + GLYPH_WIDTH - 11'd1)) begin
          column       = hmod - GLYPH_OFFSET;
          column_valid = 1'b1;
        end
      end
      REGION_LEFT: begin
        column       = aligned.hcount - LEFT_H_START;
        column_valid = column < GLYPH_WIDTH;
      end
      REGION_RIGHT: begin
        column       = aligned.hcount - RIGHT_H_START;
        column_valid = column < GLYPH_WIDTH;
      end
      default: ;
    endcase

    pixel_on = column_valid && char_pixels[3'd7 - column[2:0]] &&
               !aligned.hblnk && !aligned.vblnk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= aligned.hcount;
      vga_out.vcount <= aligned.vcount;
      vga_out.hsync  <= aligned.hsync;
      vga_out.vsync  <= aligned.vsync;
      vga_out.hblnk  <= aligned.hblnk;
      vga_out.vblnk  <= aligned.vblnk;
      vga_out.rgb    <= pixel_on ? LETTER_COLOR : aligned.rgb;
    end
  end

endmodule
